nonce_result_scan: RTL and testbench
====================================

// Module: nonce_result_scan
// PURPOSE
//  Downstream of the multi-nonce SHA256 miner. Reads the NUM_NONCES hash words the
//  miner wrote to memory and compares each against a 32-bit target. Reports the
//  lowest nonce whose hash is below target, plus the minimum hash and its nonce.
//  Writes a 3-word result record back to memory and pulses completion to the
//  controller.
// PARAMETERS
//  NUM_NONCES  16  hash words scanned (one per nonce); power of 2, 2..256
//  IDX_W       $clog2(NUM_NONCES)  nonce index width
// PORTS
//  clk             in   1   single clock; memory is also clocked by it
//  reset           in   1   synchronous, active-high reset
//  start           in   1   begin a scan (sampled only in IDLE)
//  result_addr     in   16  base address of the hash words; sampled at start
//  report_addr     in   16  base address of the 3-word record; sampled at start
//  target          in   32  unsigned threshold; sampled at start
//  done            out  1   high from completion until the next accepted start
//  found           out  1   valid with done: some hash < target
//  found_nonce     out  IDX_W  valid with done: lowest qualifying index (0 if !found)
//  mem_clk         out  1   = clk
//  mem_we          out  1   memory write enable
//  mem_addr        out  16  memory address
//  mem_write_data  out  32  memory write data
//  mem_read_data   in   32  word at mem_addr registered on the previous clk edge (1-cycle read)
// BEHAVIOUR
//  Reset values: state=IDLE; done, found, mem_we = 0; found_nonce, mem_addr,
//   mem_write_data = 0; all accumulators cleared.
//  States: IDLE -> ISSUE -> DRAIN -> WR_FLAG -> WR_MIN -> WR_IDX -> FIN -> IDLE.
//  Accept edge E0 (IDLE & start):
//   - latch target and report_addr; mem_addr <= result_addr; mem_we <= 0
//   - done <= 0; found <= 0; min_hash <= 32'hFFFFFFFF; min_idx <= 0
//  ISSUE: at Ek drive mem_addr = result_addr+k, for k = 0..NUM_NONCES-1.
//   Address arithmetic is modulo 2^16, so wrap at 0xFFFF is legal.
//  Compare: word i is sampled at edge E(i+2), i = 0..NUM_NONCES-1.
//   ISSUE and compare overlap; DRAIN covers the last compare cycles.
//   - qualify: hash < target, unsigned and strict; equal does not qualify
//   - first qualifying index latches found_nonce and sets found; later hits ignored
//   - hash < min_hash (strict): update min; ties keep the lower index
//  Writes, one per cycle, mem_we = 1:
//   - E(N+2)  report_addr+0 <- {found, 15'b0, 16'(found_nonce)}
//   - E(N+3)  report_addr+1 <- min_hash
//   - E(N+4)  report_addr+2 <- 32'(min_idx)
//  FIN at E(N+5): mem_we <= 0; done <= 1; return to IDLE.
//   Latency start->done = NUM_NONCES+5 edges (21 at default).
//  done, found and found_nonce hold until the next accepted start.
//  start outside IDLE is ignored. start held high in IDLE re-launches immediately.
//  reset mid-operation: IDLE at the next edge; mem_we = 0 that cycle; no further
//   writes; done = 0.
//  Record may overlap the hash region: all reads complete before the first write.
//  Port inputs other than start are don't-care outside the accept edge.
// STRUCTURE
//  mining_pkg (shared with the miner):
//   - scan_state_t enum
//   - NUM_NONCES default
//   - record offsets REC_FLAG=0, REC_MIN=1, REC_IDX=2
//   - FOUND_BIT=31
//  Sub-module nonce_min_tracker: registered found/first-index and min/argmin
//   update. Inputs: data, index, valid, clear. Top keeps FSM and address counters.
// TESTING
//  1. All 16 hashes >= target=0x00001000, min 0x00002000 at idx 11
//     -> record {0x00000000, 0x00002000, 0x0000000B}; found=0; done at edge 21.
//  2. hash[5]=0x00000FFF, hash[9]=0x00000001, target=0x00001000
//     -> found=1, found_nonce=5, record {0x80000005, 0x00000001, 0x00000009}.
//  3. hash[3]=hash[7]=0x00000010 (global min), target=0x00000010
//     -> found=0 (equal not below); min_idx=3.
//  4. result_addr=0xFFF8, report_addr=0x0100
//     -> reads 0xFFF8..0x0007 with wrap; writes exactly 0x0100..0x0102.
//  5. reset asserted at edge E6 of a scan -> mem_we never 1, done=0;
//     a new start completes normally in 21 edges.
//  6. start pulsed again at E4 and E(N+3) -> ignored;
//     exactly one record written; done stays high until a later start in IDLE.

Source files
------------

// File: rtl/mining_pkg.sv
// Shared definitions for the nonce miner and its result scanner.
package mining_pkg;

  localparam int NUM_NONCES_DEF = 16;

  localparam logic [15:0] REC_FLAG = 16'd0;
  localparam logic [15:0] REC_MIN  = 16'd1;
  localparam logic [15:0] REC_IDX  = 16'd2;

  localparam int FOUND_BIT = 31;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_DRAIN   = 3'd2,
    S_WR_FLAG = 3'd3,
    S_WR_MIN  = 3'd4,
    S_WR_IDX  = 3'd5,
    S_FIN     = 3'd6
  } scan_state_t;

  // First record word: found flag in the top bit, qualifying index in the low half.
  function automatic logic [31:0] flag_word(input logic found, input logic [15:0] idx);
    logic [31:0] w;
    w = {16'd0, idx};
    w[FOUND_BIT] = found;
    return w;
  endfunction

endpackage

// File: rtl/nonce_result_scan_min_tracker.sv
// Tracks the first hash below target and the running minimum hash with its index.
module nonce_min_tracker
  import mining_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [31:0]      data,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      target,
  output logic             found,
  output logic [IDX_W-1:0] first_idx,
  output logic [31:0]      min_hash,
  output logic [IDX_W-1:0] min_idx
);

  logic             found_q, found_d;
  logic [IDX_W-1:0] first_idx_q, first_idx_d;
  logic [31:0]      min_hash_q, min_hash_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;

  // Strict compares: equal-to-target never qualifies, min ties keep the earlier index.
  always_comb begin
    found_d     = found_q;
    first_idx_d = first_idx_q;
    min_hash_d  = min_hash_q;
    min_idx_d   = min_idx_q;
    if (clear) begin
      found_d     = 1'b0;
      first_idx_d = '0;
      min_hash_d  = 32'hFFFF_FFFF;
      min_idx_d   = '0;
    end else if (valid) begin
      if (!found_q && (data < target)) begin
        found_d     = 1'b1;
        first_idx_d = index;
      end else begin
        found_d     = found_q;
      end
      if (data < min_hash_q) begin
        min_hash_d = data;
        min_idx_d  = index;
      end else begin
        min_hash_d = min_hash_q;
      end
    end else begin
      found_d = found_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      found_q     <= 1'b0;
      first_idx_q <= '0;
      min_hash_q  <= 32'hFFFF_FFFF;
      min_idx_q   <= '0;
    end else begin
      found_q     <= found_d;
      first_idx_q <= first_idx_d;
      min_hash_q  <= min_hash_d;
      min_idx_q   <= min_idx_d;
    end
  end

  assign found     = found_q;
  assign first_idx = first_idx_q;
  assign min_hash  = min_hash_q;
  assign min_idx   = min_idx_q;

endmodule

// File: rtl/nonce_result_scan.sv
// Scans NUM_NONCES hash words against a target and writes a 3-word result record.
module nonce_result_scan
  import mining_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEF,
  parameter int IDX_W      = $clog2(NUM_NONCES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      result_addr,
  input  logic [15:0]      report_addr,
  input  logic [31:0]      target,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] found_nonce,
  output logic             mem_clk,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             done_q, done_d;
  logic [31:0]      target_q, target_d;
  logic [15:0]      report_q, report_d;

  logic             trk_clear_s, trk_valid_s;
  logic [IDX_W-1:0] trk_index_s;
  logic             found_s;
  logic [IDX_W-1:0] found_nonce_s;
  logic [31:0]      min_hash_s;
  logic [IDX_W-1:0] min_idx_s;

  nonce_min_tracker #(.IDX_W(IDX_W)) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .clear     (trk_clear_s),
    .valid     (trk_valid_s),
    .data      (mem_read_data),
    .index     (trk_index_s),
    .target    (target_q),
    .found     (found_s),
    .first_idx (found_nonce_s),
    .min_hash  (min_hash_s),
    .min_idx   (min_idx_s)
  );

  // cnt counts edges since accept minus one; the word for index cnt-1 is on the read bus.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    done_d      = done_q;
    target_d    = target_q;
    report_d    = report_q;
    trk_clear_s = 1'b0;
    trk_valid_s = 1'b0;
    trk_index_s = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d    = target;
          report_d    = report_addr;
          addr_d      = result_addr;
          we_d        = 1'b0;
          done_d      = 1'b0;
          cnt_d       = '0;
          trk_clear_s = 1'b1;
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        addr_d = addr_q + 16'd1;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q != '0) begin
          trk_valid_s = 1'b1;
          trk_index_s = IDX_W'(cnt_q - CNT_ONE);
        end else begin
          trk_valid_s = 1'b0;
        end
        if (cnt_q == CNT_W'(NUM_NONCES - 2)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        cnt_d       = cnt_q + CNT_ONE;
        trk_valid_s = 1'b1;
        trk_index_s = IDX_W'(cnt_q - CNT_ONE);
        if (cnt_q == CNT_W'(NUM_NONCES)) begin
          state_d = S_WR_FLAG;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_WR_FLAG: begin
        we_d    = 1'b1;
        addr_d  = report_q + REC_FLAG;
        wdata_d = flag_word(found_s, 16'(found_nonce_s));
        state_d = S_WR_MIN;
      end
      S_WR_MIN: begin
        we_d    = 1'b1;
        addr_d  = report_q + REC_MIN;
        wdata_d = min_hash_s;
        state_d = S_WR_IDX;
      end
      S_WR_IDX: begin
        we_d    = 1'b1;
        addr_d  = report_q + REC_IDX;
        wdata_d = 32'(min_idx_s);
        state_d = S_FIN;
      end
      S_FIN: begin
        we_d    = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        we_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= 16'd0;
      we_q     <= 1'b0;
      wdata_q  <= 32'd0;
      done_q   <= 1'b0;
      target_q <= 32'd0;
      report_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      target_q <= target_d;
      report_q <= report_d;
    end
  end

  assign mem_clk        = clk;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign done           = done_q;
  assign found          = found_s;
  assign found_nonce    = found_nonce_s;

endmodule

// File: tb/tb_nonce_result_scan.sv
// Randomized self-checking bench for nonce_result_scan with a memory model and reference scan.
module tb_nonce_result_scan;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] result_addr = 16'd0;
  logic [15:0] report_addr = 16'd0;
  logic [31:0] target = 32'd0;
  logic        done, found, mem_clk, mem_we;
  logic [3:0]  found_nonce;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] hash_src [N];
  logic [15:0] hash_base = 16'd0;
  logic [31:0] wmem [65536];
  logic [15:0] rd_off;
  logic [15:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  int checks = 0;
  int errors = 0;

  nonce_result_scan dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .result_addr    (result_addr),
    .report_addr    (report_addr),
    .target         (target),
    .done           (done),
    .found          (found),
    .found_nonce    (found_nonce),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  assign rd_off = mem_addr - hash_base;

  // One-cycle synchronous memory; the hash region is served from hash_src.
  always @(posedge clk) begin
    if (mem_we) wmem[mem_addr] <= mem_write_data;
    if (rd_off < 16'd16) mem_read_data <= hash_src[rd_off[3:0]];
    else mem_read_data <= wmem[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_write_data);
    end
  end

  // Reference: minimum value first, then its lowest index; lowest index strictly below target.
  task automatic model(input logic [31:0] tgt, output logic f, output logic [3:0] fn,
                       output logic [31:0] mh, output logic [3:0] mi);
    mh = 32'hFFFF_FFFF;
    for (int i = 0; i < N; i++) if (hash_src[i] < mh) mh = hash_src[i];
    mi = 4'd0;
    for (int i = N - 1; i >= 0; i--) if (hash_src[i] == mh) mi = 4'(i);
    f = 1'b0;
    fn = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hash_src[i] < tgt) begin
        f = 1'b1;
        fn = 4'(i);
      end
    end
  endtask

  task automatic run_scan(input logic [15:0] base, input logic [15:0] rep, input logic [31:0] tgt,
                          input int p1, input int p2, output int edges, output logic d0);
    hash_base = base;
    @(negedge clk);
    result_addr = base;
    report_addr = rep;
    target = tgt;
    start = 1'b1;
    @(posedge clk);
    #1;
    d0 = done;
    start = 1'b0;
    result_addr = 16'($urandom);
    report_addr = 16'($urandom);
    target = $urandom;
    edges = 0;
    while (edges < 100) begin
      @(negedge clk);
      start = ((edges + 1) == p1) || ((edges + 1) == p2);
      @(posedge clk);
      edges++;
      #1;
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic test_scan_vector(input string name, input logic [15:0] base, input logic [15:0] rep,
                                  input logic [31:0] tgt, input int p1, input int p2);
    int edges, wb;
    logic d0, ef;
    logic [3:0] efn, emi;
    logic [31:0] emh;
    model(tgt, ef, efn, emh, emi);
    wb = wr_addr_q.size();
    run_scan(base, rep, tgt, p1, p2, edges, d0);
    checks++;
    if (edges !== 21) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, want 21", name, edges);
    end
    checks++;
    if (d0 !== 1'b0) begin
      errors++;
      $display("FAIL %s done_clear_at_accept: got %b want 0", name, d0);
    end
    checks++;
    if ({found, found_nonce} !== {ef, efn}) begin
      errors++;
      $display("FAIL %s found: got %b/%0d want %b/%0d", name, found, found_nonce, ef, efn);
    end
    checks++;
    if (wr_addr_q.size() - wb !== 3) begin
      errors++;
      $display("FAIL %s write_count: got %0d want 3", name, wr_addr_q.size() - wb);
    end else begin
      checks++;
      if ({wr_addr_q[wb], wr_addr_q[wb+1], wr_addr_q[wb+2]} !== {rep, rep + 16'd1, rep + 16'd2}) begin
        errors++;
        $display("FAIL %s write_addr: got %h %h %h want %h..+2", name,
                 wr_addr_q[wb], wr_addr_q[wb+1], wr_addr_q[wb+2], rep);
      end
      checks++;
      if ({wr_data_q[wb], wr_data_q[wb+1], wr_data_q[wb+2]} !==
          {ef, 27'd0, efn, emh, 28'd0, emi}) begin
        errors++;
        $display("FAIL %s record: got %h %h %h want %h %h %h", name,
                 wr_data_q[wb], wr_data_q[wb+1], wr_data_q[wb+2],
                 {ef, 27'd0, efn}, emh, {28'd0, emi});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done, found, found_nonce, mem_we, mem_addr, mem_write_data} !== 55'd0) begin
      errors++;
      $display("FAIL reset_values: got done=%b found=%b nonce=%0d we=%b addr=%h wd=%h want all 0",
               done, found, found_nonce, mem_we, mem_addr, mem_write_data);
    end
    @(negedge clk);
    checks++;
    if (mem_clk !== 1'b0) begin
      errors++;
      $display("FAIL mem_clk: got %b want 0 at clk low", mem_clk);
    end
    reset = 1'b0;
  endtask

  task automatic test_no_hit();
    for (int i = 0; i < N; i++) hash_src[i] = 32'h0000_2001 + 32'($urandom_range(0, 1000000));
    hash_src[11] = 32'h0000_2000;
    test_scan_vector("no_hit", 16'h0040, 16'h0200, 32'h0000_1000, 0, 0);
  endtask

  task automatic test_hits();
    for (int i = 0; i < N; i++) hash_src[i] = 32'h0000_1000 + 32'($urandom_range(0, 1000000));
    hash_src[5] = 32'h0000_0FFF;
    hash_src[9] = 32'h0000_0001;
    test_scan_vector("two_hits", 16'h0300, 16'h0400, 32'h0000_1000, 0, 0);
  endtask

  task automatic test_equal();
    for (int i = 0; i < N; i++) hash_src[i] = 32'h0000_0100 + 32'($urandom_range(0, 1000));
    hash_src[3] = 32'h0000_0010;
    hash_src[7] = 32'h0000_0010;
    test_scan_vector("equal_target", 16'h1000, 16'h2000, 32'h0000_0010, 0, 0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < N; i++) hash_src[i] = $urandom;
    test_scan_vector("addr_wrap", 16'hFFF8, 16'h0100, 32'h4000_0000, 0, 0);
  endtask

  task automatic test_reset_mid();
    int wb;
    for (int i = 0; i < N; i++) hash_src[i] = $urandom >> 4;
    hash_base = 16'h0500;
    wb = wr_addr_q.size();
    @(negedge clk);
    result_addr = 16'h0500;
    report_addr = 16'h0600;
    target = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({mem_we, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_outputs: got we=%b done=%b want 0 0", mem_we, done);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if ({wr_addr_q.size() != wb, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_quiet: got writes=%0d done=%b want 0 0", wr_addr_q.size() - wb, done);
    end
    test_scan_vector("after_reset", 16'h0500, 16'h0600, 32'h0100_0000, 0, 0);
  endtask

  task automatic test_restart_ignored();
    int wb;
    for (int i = 0; i < N; i++) hash_src[i] = $urandom >> 8;
    test_scan_vector("restart_ignored", 16'h0700, 16'h0800, 32'h0010_0000, 4, N + 3);
    wb = wr_addr_q.size();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({done, wr_addr_q.size() != wb} !== 2'b10) begin
      errors++;
      $display("FAIL done_hold: got done=%b extra_writes=%0d want 1 0", done, wr_addr_q.size() - wb);
    end
  endtask

  task automatic test_random();
    logic [15:0] base;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < N; i++) hash_src[i] = $urandom >> $urandom_range(0, 31);
      if ((n % 3) == 0) hash_src[$urandom_range(8, 15)] = hash_src[$urandom_range(0, 7)];
      base = 16'($urandom);
      test_scan_vector("random", base, base + 16'd32 + 16'($urandom_range(0, 1000)),
                       $urandom >> $urandom_range(0, 31), 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_no_hit();
    test_hits();
    test_equal();
    test_wrap();
    test_reset_mid();
    test_restart_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
